// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter: bus typedefs, FSM and
// owner encodings, and the latched request bundle that also drives the RAM.
package mem_arbiter_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] ram_addr_t;
  typedef logic [31:0] ram_data_t;

  typedef enum logic {CHIP_DISABLE = 1'b0, CHIP_ENABLE = 1'b1} chip_status_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;

  typedef enum logic {OWNER_INST, OWNER_DATA} arb_owner_t;

  typedef struct packed {
    chip_status_t ce;
    logic         we;
    ram_addr_t    addr;
    ram_data_t    wdata;
    logic [3:0]   sel;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_IDLE = '{ce: CHIP_DISABLE, we: 1'b0, addr: '0, wdata: '0, sel: '0};

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch and load/store: one access at a time
// (grant, issue, wait latency, capture, ack), data-first with a fetch starvation guard.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_sel,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata,
  output logic        stall_req
);

  localparam logic [3:0] LAT = 4'(RAM_LATENCY);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  arb_state_t state, state_nxt;
  arb_owner_t owner;
  mem_req_t   req_q, ram_req;
  logic [3:0] lat_cnt, starve_cnt;
  logic       grant, grant_inst;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_inst = 1'b0;
    ram_req    = req_q;
    ram_req.ce = CHIP_DISABLE;
    case (state)
      IDLE: if (inst_req || data_req) begin
        grant      = 1'b1;
        // fetch only wins a tie once data has had its run of consecutive grants
        grant_inst = inst_req && (!data_req || starve_cnt == LIM);
        state_nxt  = ISSUE;
      end
      ISSUE: begin
        ram_req.ce = req_q.ce;
        state_nxt  = WAIT;
      end
      WAIT:    if (lat_cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWNER_INST;
      req_q      <= MEM_REQ_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_data  <= '0;
      data_rdata <= '0;
    end else begin
      state    <= state_nxt;
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      if (grant) begin
        owner       <= grant_inst ? OWNER_INST : OWNER_DATA;
        req_q.ce    <= CHIP_ENABLE;
        req_q.we    <= grant_inst ? 1'b0 : data_we;
        req_q.addr  <= grant_inst ? inst_addr : data_addr;
        req_q.wdata <= grant_inst ? '0 : data_wdata;
        req_q.sel   <= grant_inst ? 4'hF : data_sel;
        if (grant_inst || !inst_req) starve_cnt <= '0;
        else if (starve_cnt != LIM)  starve_cnt <= starve_cnt + 4'd1;
      end
      if (state == ISSUE) lat_cnt <= LAT;
      else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
        if (lat_cnt == 4'd1) begin
          if (owner == OWNER_INST) begin
            inst_data <= ram_rdata;
            inst_ack  <= 1'b1;
          end else begin
            data_rdata <= ram_rdata;
            data_ack   <= 1'b1;
          end
        end
      end
    end
  end

  assign ram_ce    = ram_req.ce;
  assign ram_we    = ram_req.we;
  assign ram_addr  = ram_req.addr;
  assign ram_wdata = ram_req.wdata;
  assign ram_sel   = ram_req.sel;

  assign stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Random + directed bench for mem_arbiter: a transaction-level arbitration model
// feeds a scoreboard; a negedge monitor checks RAM issue, acks, data and stall.
module tb_mem_arbiter;
  localparam int L   = 3;
  localparam int LIM = 4;

  logic        clk = 1'b0, rst;
  logic        inst_req, inst_ack, data_req, data_we, data_ack;
  logic [31:0] inst_addr, inst_data, data_addr, data_wdata, data_rdata;
  logic [3:0]  data_sel, ram_sel;
  logic        ram_ce, ram_we, stall_req;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  mem_arbiter #(.RAM_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_data(inst_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_sel(data_sel), .data_ack(data_ack), .data_rdata(data_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          inst;
    bit          we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    int          iss, ack;
  } txn_t;

  txn_t        iss_q[$], ack_q[$];
  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] rsp[int];
  int          cyc = 0, checks = 0, errors = 0;
  bit          chk_en = 1'b0, seq_on = 1'b0;
  bit          seq[$];
  int          next_free = 0, starve = 0;
  int          last_iack = -1, last_dack = -1;
  logic [31:0] last_idata = '0, last_ddata = '0;
  int          inst_pct = 0, data_pct = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // cycle counter and RAM read-data return path (garbage when nothing is due)
  initial begin
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rsp.exists(cyc)) begin
        ram_rdata = rsp[cyc];
        rsp.delete(cyc);
      end else ram_rdata = $urandom;
    end
  end

  // negedge: scoreboard monitor, RAM storage, then the arbitration model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit ec, ei, ed;
        ec = iss_q.size() > 0 && iss_q[0].iss == cyc;
        chk("ram_ce", 32'(ram_ce), 32'(ec));
        if (ec) begin
          if (ram_ce === 1'b1) begin
            chk("ram_addr", ram_addr, iss_q[0].addr);
            chk("ram_we", 32'(ram_we), 32'(iss_q[0].we));
            if (iss_q[0].we) begin
              chk("ram_wdata", ram_wdata, iss_q[0].wdata);
              chk("ram_sel", 32'(ram_sel), 32'(iss_q[0].sel));
            end
          end
          void'(iss_q.pop_front());
        end
        ei = ack_q.size() > 0 && ack_q[0].ack == cyc && ack_q[0].inst;
        ed = ack_q.size() > 0 && ack_q[0].ack == cyc && !ack_q[0].inst;
        chk("inst_ack", 32'(inst_ack), 32'(ei));
        chk("data_ack", 32'(data_ack), 32'(ed));
        chk("stall_req", 32'(stall_req), 32'((inst_req && !ei) || (data_req && !ed)));
        if (ei || ed) begin
          if (ei && inst_ack === 1'b1) chk("inst_data", inst_data, ack_q[0].rdata);
          if (ed && data_ack === 1'b1 && !ack_q[0].we) chk("data_rdata", data_rdata, ack_q[0].rdata);
          void'(ack_q.pop_front());
        end
        if (inst_ack === 1'b1) begin
          last_iack = cyc; last_idata = inst_data;
          if (seq_on) seq.push_back(1'b1);
        end
        if (data_ack === 1'b1) begin
          last_dack = cyc; last_ddata = data_rdata;
          if (seq_on) seq.push_back(1'b0);
        end
      end
      if (ram_ce === 1'b1) begin
        logic [31:0] old;
        old = env_mem.exists(ram_addr) ? env_mem[ram_addr] : init_word(ram_addr);
        rsp[cyc + L] = old;
        if (ram_we) env_mem[ram_addr] = merge(old, ram_wdata, ram_sel);
      end
      if (rst) begin
        iss_q.delete(); ack_q.delete();
        starve = 0; next_free = cyc + 1;
      end else if (cyc >= next_free && (inst_req || data_req)) begin
        txn_t t;
        logic [31:0] old;
        t.inst  = inst_req && (!data_req || starve == LIM);
        t.we    = t.inst ? 1'b0 : data_we;
        t.addr  = t.inst ? inst_addr : data_addr;
        t.wdata = data_wdata;
        t.sel   = data_sel;
        old     = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr);
        t.rdata = old;
        if (t.we) ref_mem[t.addr] = merge(old, t.wdata, t.sel);
        t.iss = cyc + 1;
        t.ack = cyc + 2 + L;
        iss_q.push_back(t); ack_q.push_back(t);
        if (t.inst || !inst_req) starve = 0;
        else if (starve < LIM) starve++;
        next_free = cyc + L + 3;
      end
    end
  end

  // advance one cycle: requesters drop after their ack, random ones may re-request
  task automatic step();
    @(posedge clk); #1;
    if (inst_req && last_iack == cyc - 1) inst_req = 1'b0;
    if (data_req && last_dack == cyc - 1) data_req = 1'b0;
    if (!rst) begin
      if (!inst_req && int'($urandom_range(0, 99)) < inst_pct) begin
        inst_req  = 1'b1;
        inst_addr = 32'h100 + $urandom_range(0, 63);
      end
      if (!data_req && int'($urandom_range(0, 99)) < data_pct) begin
        data_req   = 1'b1;
        data_we    = 1'($urandom_range(0, 1));
        data_addr  = 32'h100 + $urandom_range(0, 63);
        data_wdata = $urandom;
        data_sel   = 4'($urandom_range(1, 15));
      end
    end
  endtask

  task automatic drain();
    int b = 0;
    inst_pct = 0; data_pct = 0;
    while ((inst_req || data_req || ack_q.size() != 0) && b < 200) begin step(); b++; end
    chk("drain_done", 32'(b < 200), 32'd1);
  endtask

  task automatic lone(input bit is_inst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input bit do_data, input logic [31:0] exp, input string nm);
    int c0, b, got;
    step();
    if (is_inst) begin
      inst_req = 1'b1; inst_addr = a;
    end else begin
      data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd; data_sel = s;
    end
    c0 = cyc; b = 0;
    while ((is_inst ? last_iack : last_dack) <= c0 && b < 100) begin step(); b++; end
    got = is_inst ? last_iack : last_dack;
    chk({nm, "_latency"}, 32'(got - c0), 32'(L + 2));
    if (do_data) chk({nm, "_data"}, is_inst ? last_idata : last_ddata, exp);
    step();
  endtask

  initial begin
    int c0, b;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_sel = '0;
    env_mem[32'h40] = 32'h2408_0005;
    ref_mem[32'h40] = 32'h2408_0005;
    repeat (3) step();
    @(negedge clk);
    chk("rst_inst_ack", 32'(inst_ack), 0);
    chk("rst_data_ack", 32'(data_ack), 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_data_rdata", data_rdata, 0);
    chk("rst_ram_ce", 32'(ram_ce), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_ram_sel", 32'(ram_sel), 0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    lone(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h2408_0005, "lone_fetch");
    lone(1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0, "store");
    lone(1'b0, 1'b0, 32'h2000, 32'h0, 4'h0, 1'b1, (init_word(32'h2000) & 32'hFFFF_0000) | 32'h0000_BEEF, "load_back");

    // simultaneous: data goes first, fetch takes the next free slot
    step();
    inst_req = 1'b1; inst_addr = 32'h44;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h1000; data_wdata = '0; data_sel = 4'hF;
    c0 = cyc; b = 0;
    while (last_iack <= c0 && b < 100) begin step(); b++; end
    chk("sim_data_ack_cycle", 32'(last_dack - c0), 32'(L + 2));
    chk("sim_inst_ack_cycle", 32'(last_iack - c0), 32'(2 * L + 5));
    chk("sim_data_rdata", last_ddata, init_word(32'h1000));
    chk("sim_inst_data", last_idata, init_word(32'h44));
    drain();

    // starvation: both requesters always busy
    step();
    inst_req = 1'b1; inst_addr = 32'h120;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h130; data_wdata = '0; data_sel = 4'hF;
    inst_pct = 100; data_pct = 100; seq_on = 1'b1;
    b = 0;
    while (seq.size() < 2 * (LIM + 1) && b < 300) begin step(); b++; end
    seq_on = 1'b0;
    chk("starve_seq_len", 32'(seq.size() >= 2 * (LIM + 1)), 32'd1);
    for (int i = 0; i < seq.size() && i < 2 * (LIM + 1); i++)
      chk($sformatf("starve_owner_%0d", i), 32'(seq[i]), 32'((i % (LIM + 1)) == LIM));
    drain();

    inst_pct = 40; data_pct = 60;
    repeat (2000) step();
    drain();
    inst_pct = 15; data_pct = 15;
    repeat (1000) step();
    drain();

    // reset in the middle of WAIT: no ack, held request re-granted afterwards
    step();
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000; data_wdata = '0; data_sel = 4'hF;
    c0 = cyc;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ram_ce", 32'(ram_ce), 0);
    chk("post_rst_data_ack", 32'(data_ack), 0);
    b = 0;
    while (last_dack <= c0 && b < 100) begin step(); b++; end
    chk("rst_regrant_ack_cycle", 32'(last_dack - c0), 32'(4 + L + 2));
    chk("rst_regrant_data", last_ddata, init_word(32'h3000));
    drain();
    lone(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h2408_0005, "fetch_after_rst");

    chk("scoreboard_empty", 32'(iss_q.size() + ack_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
